// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding, memory bus
// widths and requester identifiers.
package cpu_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_e;

    localparam int MEM_DATA_W = 24;
    localparam int MEM_ADDR_W = 24;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

    // One-hot request position of a requester id (bit 0 = A, bit 1 = B).
    function automatic logic [1:0] req_onehot(input logic id);
        logic [1:0] oh;
        if (id == REQ_B) begin
            oh = 2'b10;
        end else begin
            oh = 2'b01;
        end
        return oh;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Combinational two-way round-robin picker; a set mask bit removes that
// requester from consideration for the current decision.
module rr_arb2
    import cpu_mem_pkg::*;
(
    input  logic [1:0] req,
    input  logic [1:0] mask,
    input  logic       last_grant,
    output logic       gnt_valid,
    output logic       gnt_id
);

    logic [1:0] elig_s;

    assign elig_s = req & ~mask;

    // On a tie the requester that did not win last time goes first.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_id    = REQ_A;
        case (elig_s)
            2'b01: begin
                gnt_valid = 1'b1;
                gnt_id    = REQ_A;
            end
            2'b10: begin
                gnt_valid = 1'b1;
                gnt_id    = REQ_B;
            end
            2'b11: begin
                gnt_valid = 1'b1;
                gnt_id    = ~last_grant;
            end
            default: begin
                gnt_valid = 1'b0;
                gnt_id    = REQ_A;
            end
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of the 24-bit x 256-word data
// memory. Optional A-side bus lock is built when MEM_ARB_LOCK_EN is defined.
module mem_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int DATA_W = MEM_DATA_W,
    parameter int ADDR_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [ADDR_W-1:0]     a_addr,
    input  logic [DATA_W-1:0]     a_wdata,
`ifdef MEM_ARB_LOCK_EN
    input  logic                  a_lock,
`endif
    output logic                  a_ack,
    output logic [DATA_W-1:0]     a_rdata,
    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [ADDR_W-1:0]     b_addr,
    input  logic [DATA_W-1:0]     b_wdata,
    output logic                  b_ack,
    output logic [DATA_W-1:0]     b_rdata,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0]     mem_din,
    output logic                  mem_we,
    input  logic [DATA_W-1:0]     mem_dout,
    output logic                  busy
);

    arb_state_e            state_q, state_d;
    logic                  last_grant_q, last_grant_d;
    logic                  lock_held_q, lock_held_d;
    logic                  cmd_id_q, cmd_id_d;
    logic                  cmd_we_q, cmd_we_d;
    logic [ADDR_W-1:0]     cmd_addr_q, cmd_addr_d;
    logic [DATA_W-1:0]     cmd_wdata_q, cmd_wdata_d;

    logic [MEM_ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]     mem_din_q, mem_din_d;
    logic                  mem_we_q, mem_we_d;
    logic                  a_ack_q, a_ack_d;
    logic                  b_ack_q, b_ack_d;
    logic [DATA_W-1:0]     a_rdata_q, a_rdata_d;
    logic [DATA_W-1:0]     b_rdata_q, b_rdata_d;
    logic                  busy_q, busy_d;

    logic                  a_lock_s;
    logic [1:0]            arb_req_s;
    logic [1:0]            arb_mask_s;
    logic                  gnt_valid_s;
    logic                  gnt_id_s;
    logic                  grant_s;

`ifdef MEM_ARB_LOCK_EN
    assign a_lock_s = a_lock;
`else
    assign a_lock_s = 1'b0;
`endif

    // In DONE the just-served requester is still holding req, so it is masked;
    // a held lock keeps B out in every state.
    assign arb_req_s  = {b_req, a_req};
    assign arb_mask_s = ((state_q == DONE) ? req_onehot(cmd_id_q) : 2'b00)
                      | {lock_held_q, 1'b0};

    rr_arb2 u_rr_arb2 (
        .req        (arb_req_s),
        .mask       (arb_mask_s),
        .last_grant (last_grant_q),
        .gnt_valid  (gnt_valid_s),
        .gnt_id     (gnt_id_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; grant_s marks the cycle a new command is latched.
    always_comb begin
        state_d = state_q;
        grant_s = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (gnt_valid_s) begin
                    state_d = ACCESS;
                    grant_s = 1'b1;
                end else begin
                    state_d = IDLE;
                    grant_s = 1'b0;
                end
            end
            ACCESS: begin
                state_d = DONE;
                grant_s = 1'b0;
            end
            default: begin
                state_d = IDLE;
                grant_s = 1'b0;
            end
        endcase
    end

    // Command latch, lock tracking and round-robin history next-state.
    always_comb begin
        cmd_id_d     = cmd_id_q;
        cmd_we_d     = cmd_we_q;
        cmd_addr_d   = cmd_addr_q;
        cmd_wdata_d  = cmd_wdata_q;
        lock_held_d  = lock_held_q;
        last_grant_d = last_grant_q;
        if (grant_s) begin
            cmd_id_d = gnt_id_s;
            if (gnt_id_s == REQ_B) begin
                cmd_we_d    = b_we;
                cmd_addr_d  = b_addr;
                cmd_wdata_d = b_wdata;
                lock_held_d = lock_held_q;
            end else begin
                cmd_we_d    = a_we;
                cmd_addr_d  = a_addr;
                cmd_wdata_d = a_wdata;
                lock_held_d = a_lock_s;
            end
        end else begin
            cmd_id_d    = cmd_id_q;
            lock_held_d = lock_held_q;
        end
        if (state_q == DONE) begin
            last_grant_d = cmd_id_q;
        end else begin
            last_grant_d = last_grant_q;
        end
    end

    // Command and arbitration history registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_id_q     <= REQ_A;
            cmd_we_q     <= 1'b0;
            cmd_addr_q   <= {ADDR_W{1'b0}};
            cmd_wdata_q  <= {DATA_W{1'b0}};
            lock_held_q  <= 1'b0;
            last_grant_q <= REQ_B;
        end else begin
            cmd_id_q     <= cmd_id_d;
            cmd_we_q     <= cmd_we_d;
            cmd_addr_q   <= cmd_addr_d;
            cmd_wdata_q  <= cmd_wdata_d;
            lock_held_q  <= lock_held_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Output next-state: the memory bus is live only while entering/in ACCESS,
    // and the ack plus read data follow the ACCESS cycle.
    always_comb begin
        mem_we_d   = 1'b0;
        mem_addr_d = {MEM_ADDR_W{1'b0}};
        mem_din_d  = {DATA_W{1'b0}};
        a_rdata_d  = a_rdata_q;
        b_rdata_d  = b_rdata_q;
        if (state_d == ACCESS) begin
            mem_we_d   = cmd_we_d;
            mem_addr_d = {{(MEM_ADDR_W-ADDR_W){1'b0}}, cmd_addr_d};
            mem_din_d  = cmd_wdata_d;
        end else begin
            mem_we_d   = 1'b0;
            mem_addr_d = {MEM_ADDR_W{1'b0}};
            mem_din_d  = {DATA_W{1'b0}};
        end
        a_ack_d = (state_q == ACCESS) && (cmd_id_q == REQ_A);
        b_ack_d = (state_q == ACCESS) && (cmd_id_q == REQ_B);
        if (a_ack_d) begin
            a_rdata_d = cmd_we_q ? {DATA_W{1'b0}} : mem_dout;
        end else begin
            a_rdata_d = a_rdata_q;
        end
        if (b_ack_d) begin
            b_rdata_d = cmd_we_q ? {DATA_W{1'b0}} : mem_dout;
        end else begin
            b_rdata_d = b_rdata_q;
        end
        busy_d = (state_d != IDLE);
    end

    // Output registers; the async reset drops mem_we immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_we_q   <= 1'b0;
            mem_addr_q <= {MEM_ADDR_W{1'b0}};
            mem_din_q  <= {DATA_W{1'b0}};
            a_ack_q    <= 1'b0;
            b_ack_q    <= 1'b0;
            a_rdata_q  <= {DATA_W{1'b0}};
            b_rdata_q  <= {DATA_W{1'b0}};
            busy_q     <= 1'b0;
        end else begin
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            a_ack_q    <= a_ack_d;
            b_ack_q    <= b_ack_d;
            a_rdata_q  <= a_rdata_d;
            b_rdata_q  <= b_rdata_d;
            busy_q     <= busy_d;
        end
    end

    assign mem_we   = mem_we_q;
    assign mem_addr = mem_addr_q;
    assign mem_din  = mem_din_q;
    assign a_ack    = a_ack_q;
    assign b_ack    = b_ack_q;
    assign a_rdata  = a_rdata_q;
    assign b_rdata  = b_rdata_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: drivers push expected read data and memory
// writes into queues, a negedge monitor pops and compares on every ack/write.
`timescale 1ns/1ps
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_req = 1'b0, a_we = 1'b0;
    logic [7:0]  a_addr = 8'h00;
    logic [23:0] a_wdata = 24'h0;
`ifdef MEM_ARB_LOCK_EN
    logic        a_lock = 1'b0;
`endif
    logic        b_req = 1'b0, b_we = 1'b0;
    logic [7:0]  b_addr = 8'h00;
    logic [23:0] b_wdata = 24'h0;
    logic        a_ack, b_ack, mem_we, busy;
    logic [23:0] a_rdata, b_rdata, mem_addr, mem_din, mem_dout;

    logic [23:0] mem_model [256];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [23:0] exp_a[$];
    logic [23:0] exp_b[$];
    logic [23:0] wq_addr[$];
    logic [23:0] wq_data[$];
    logic        gap_en = 1'b0;
    int          last_we_cyc = -1;
    logic        prev_we = 1'b0;

    mem_arbiter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a_req    (a_req),
        .a_we     (a_we),
        .a_addr   (a_addr),
        .a_wdata  (a_wdata),
`ifdef MEM_ARB_LOCK_EN
        .a_lock   (a_lock),
`endif
        .a_ack    (a_ack),
        .a_rdata  (a_rdata),
        .b_req    (b_req),
        .b_we     (b_we),
        .b_addr   (b_addr),
        .b_wdata  (b_wdata),
        .b_ack    (b_ack),
        .b_rdata  (b_rdata),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_we   (mem_we),
        .mem_dout (mem_dout),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory with combinational read.
    assign mem_dout = mem_model[mem_addr[7:0]];
    always @(posedge clk) begin
        if (mem_we) mem_model[mem_addr[7:0]] <= mem_din;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic miss(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event with empty scoreboard or timeout (cycle %0d)", name, cyc);
    endtask

    // Monitor: compares every ack and memory write against the queues.
    always @(negedge clk) begin
        if (rst_n) begin
            if (a_ack) begin
                if (exp_a.size() == 0) miss("a_ack_unexpected");
                else chk("a_rdata", 32'(a_rdata), 32'(exp_a.pop_front()));
            end
            if (b_ack) begin
                if (exp_b.size() == 0) miss("b_ack_unexpected");
                else chk("b_rdata", 32'(b_rdata), 32'(exp_b.pop_front()));
            end
            if (a_ack && b_ack) miss("dual_ack");
            if (mem_we) begin
                chk("mem_we_single_cycle", 32'(prev_we), 32'h0);
                if (wq_addr.size() == 0) miss("mem_write_unexpected");
                else begin
                    chk("mem_addr", 32'(mem_addr), 32'(wq_addr.pop_front()));
                    chk("mem_din", 32'(mem_din), 32'(wq_data.pop_front()));
                end
                if (gap_en && last_we_cyc >= 0) chk("access_gap", 32'(cyc - last_we_cyc), 32'd2);
            end
            if (!busy) begin
                chk("idle_mem_we", 32'(mem_we), 32'h0);
                chk("idle_mem_addr", 32'(mem_addr), 32'h0);
                chk("idle_mem_din", 32'(mem_din), 32'h0);
            end
        end
        prev_we <= mem_we;
        if (!gap_en) last_we_cyc <= -1;
        else if (mem_we) last_we_cyc <= cyc;
    end

    task automatic a_cmd(input logic we, input logic [7:0] addr, input logic [23:0] wd,
                         input logic [23:0] exp_rd, input int exp_lat);
        int  t0;
        int  n;
        logic got;
        t0 = cyc;
        n = 0;
        got = 1'b0;
        exp_a.push_back(exp_rd);
        a_we = we; a_addr = addr; a_wdata = wd; a_req = 1'b1;
        while (!got && n < 64) begin
            @(negedge clk);
            n++;
            got = a_ack;
        end
        if (!got) miss("a_ack_timeout");
        else chk("a_latency", 32'(cyc - t0), 32'(exp_lat));
        @(posedge clk); #1;
        a_req = 1'b0;
    endtask

    task automatic b_cmd(input logic we, input logic [7:0] addr, input logic [23:0] wd,
                         input logic [23:0] exp_rd, input int exp_lat);
        int  t0;
        int  n;
        logic got;
        t0 = cyc;
        n = 0;
        got = 1'b0;
        exp_b.push_back(exp_rd);
        b_we = we; b_addr = addr; b_wdata = wd; b_req = 1'b1;
        while (!got && n < 64) begin
            @(negedge clk);
            n++;
            got = b_ack;
        end
        if (!got) miss("b_ack_timeout");
        else chk("b_latency", 32'(cyc - t0), 32'(exp_lat));
        @(posedge clk); #1;
        b_req = 1'b0;
    endtask

    task automatic push_wr(input logic [23:0] addr, input logic [23:0] data);
        wq_addr.push_back(addr);
        wq_data.push_back(data);
    endtask

    initial begin
        // Reset state.
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_a_ack", 32'(a_ack), 32'h0);
        chk("rst_b_ack", 32'(b_ack), 32'h0);
        chk("rst_a_rdata", 32'(a_rdata), 32'h0);
        chk("rst_b_rdata", 32'(b_rdata), 32'h0);
        chk("rst_mem_we", 32'(mem_we), 32'h0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h0);
        chk("rst_mem_din", 32'(mem_din), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // A write then read back.
        push_wr(24'h000005, 24'hABCDEF);
        a_cmd(1'b1, 8'h05, 24'hABCDEF, 24'h000000, 2);
        a_cmd(1'b0, 8'h05, 24'h000000, 24'hABCDEF, 2);

        // Simultaneous requests from reset: A first, B in the next ACCESS.
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        fork
            a_cmd(1'b0, 8'h05, 24'h000000, 24'hABCDEF, 2);
            b_cmd(1'b0, 8'h05, 24'h000000, 24'hABCDEF, 4);
        join

        // Sustained traffic: strict alternation, one access every 2 cycles.
        for (int i = 0; i < 4; i++) begin
            push_wr(24'(8'h20 + 8'(i)), 24'hA00000 + 24'(i));
            push_wr(24'(8'h30 + 8'(i)), 24'hB00000 + 24'(i));
        end
        gap_en = 1'b1;
        fork
            begin
                for (int i = 0; i < 4; i++)
                    a_cmd(1'b1, 8'h20 + 8'(i), 24'hA00000 + 24'(i), 24'h000000, (i == 0) ? 2 : 3);
            end
            begin
                for (int j = 0; j < 4; j++)
                    b_cmd(1'b1, 8'h30 + 8'(j), 24'hB00000 + 24'(j), 24'h000000, (j == 0) ? 4 : 3);
            end
        join
        gap_en = 1'b0;
        a_cmd(1'b0, 8'h33, 24'h000000, 24'hB00003, 2);

        // B write followed by A read of the same address.
        push_wr(24'h000010, 24'h123456);
        fork
            b_cmd(1'b1, 8'h10, 24'h123456, 24'h000000, 2);
            begin
                @(posedge clk); #1;
                a_cmd(1'b0, 8'h10, 24'h000000, 24'h123456, 3);
            end
        join

`ifdef MEM_ARB_LOCK_EN
        // Locked read keeps B out until A's unlocked write completes.
        push_wr(24'h000006, 24'h0C0C0C);
        fork
            begin
                a_lock = 1'b1;
                a_cmd(1'b0, 8'h05, 24'h000000, 24'hABCDEF, 2);
                a_lock = 1'b0;
                a_cmd(1'b1, 8'h06, 24'h0C0C0C, 24'h000000, 2);
            end
            begin
                @(posedge clk); #1;
                b_cmd(1'b0, 8'h06, 24'h000000, 24'h0C0C0C, 6);
            end
        join
`endif

        // Reset during the ACCESS cycle of a write.
        a_we = 1'b1; a_addr = 8'h05; a_wdata = 24'h555555; a_req = 1'b1;
        @(posedge clk); #1;
        chk("access_mem_we", 32'(mem_we), 32'h1);
        chk("access_mem_addr", 32'(mem_addr), 32'h000005);
        chk("access_busy", 32'(busy), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_mem_we", 32'(mem_we), 32'h0);
        chk("midrst_mem_addr", 32'(mem_addr), 32'h0);
        chk("midrst_busy", 32'(busy), 32'h0);
        chk("midrst_a_ack", 32'(a_ack), 32'h0);
        a_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        a_cmd(1'b0, 8'h05, 24'h000000, 24'hABCDEF, 2);

        repeat (3) @(posedge clk);
        #1;
        if (exp_a.size() != 0) miss("a_scoreboard_leftover");
        if (exp_b.size() != 0) miss("b_scoreboard_leftover");
        if (wq_addr.size() != 0) miss("write_scoreboard_leftover");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
